// File: rtl/imem_load_arbiter_pkg.sv
// Shared types and sizing for the instruction-memory load/fetch arbiter.
package imem_pkg;

  localparam int INS_ADDRESS_DEF = 9;
  localparam int INS_W_DEF       = 32;
  localparam int IMEM_WA_W       = INS_ADDRESS_DEF - 2;
  localparam int IMEM_DEPTH      = 2 ** IMEM_WA_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2,
    RUN    = 2'd3
  } imem_state_e;

endpackage

// File: rtl/imem_load_arbiter_load_counter.sv
// Loader write pointer and remaining-word count; the pointer wraps at memory depth.
module imem_load_counter #(
  parameter int WA_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [WA_W:0]   i_count,
  input  logic            i_step,
  output logic [WA_W-1:0] o_wa,
  output logic            o_last
);

  localparam logic [WA_W-1:0] ONE_WA  = 1;
  localparam logic [WA_W:0]   ONE_REM = 1;

  logic [WA_W-1:0] r_wa;
  logic [WA_W:0]   r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wa  <= '0;
      r_rem <= '0;
    end else if (i_start) begin
      r_wa  <= '0;
      r_rem <= i_count;
    end else if (i_step) begin
      r_wa  <= r_wa + ONE_WA;
      r_rem <= r_rem - ONE_REM;
    end
  end

  assign o_wa   = r_wa;
  assign o_last = (r_rem == ONE_REM);

endmodule

// File: rtl/imem_load_arbiter.sv
// Single instruction-memory port shared by the program loader (priority) and core fetch.
module imem_load_arbiter
  import imem_pkg::*;
#(
  parameter int INS_ADDRESS = INS_ADDRESS_DEF,
  parameter int INS_W       = INS_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_load_start,
  input  logic [INS_ADDRESS-2:0] i_load_count,
  input  logic                   i_ld_valid,
  input  logic [INS_W-1:0]       i_ld_data,
  output logic                   o_ld_ready,
  output logic                   o_load_done,
  input  logic                   i_fetch_req,
  input  logic [INS_ADDRESS-1:0] i_fetch_addr,
  output logic [INS_W-1:0]       o_fetch_rd,
  output logic                   o_fetch_valid,
  output logic                   o_fetch_stall,
  output logic                   o_fetch_err,
  output logic [INS_ADDRESS-3:0] o_mem_ra,
  output logic                   o_mem_we,
  output logic [INS_ADDRESS-3:0] o_mem_wa,
  output logic [INS_W-1:0]       o_mem_wd,
  input  logic [INS_W-1:0]       i_mem_rd
);

  localparam int WA_W = INS_ADDRESS - 2;

  imem_state_e     r_state;
  imem_state_e     w_state_next;
  logic            w_start;
  logic            w_hs;
  logic            w_run_req;
  logic            w_issue;
  logic            w_misalign;
  logic            w_last;
  logic [WA_W-1:0] w_wa;

  logic            r_mem_we;
  logic [WA_W-1:0] r_mem_wa;
  logic [INS_W-1:0] r_mem_wd;
  logic [WA_W-1:0] r_ra;
  logic            r_fetch_valid;
  logic            r_fetch_err;
  logic [INS_W-1:0] r_rd_hold;

  assign w_start    = i_load_start && (r_state == IDLE || r_state == RUN);
  assign w_hs       = (r_state == LOAD) && i_ld_valid;
  // A load_start in RUN squashes the fetch presented in the same cycle.
  assign w_run_req  = (r_state == RUN) && i_fetch_req && !i_load_start;
  assign w_issue    = w_run_req && (i_fetch_addr[1:0] == 2'b00);
  assign w_misalign = w_run_req && (i_fetch_addr[1:0] != 2'b00);

  imem_load_counter #(.WA_W(WA_W)) u_load_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_count (i_load_count),
    .i_step  (w_hs),
    .o_wa    (w_wa),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, RUN: if (i_load_start) w_state_next = (i_load_count == '0) ? FINISH : LOAD;
      LOAD:      if (w_hs && w_last) w_state_next = FINISH;
      FINISH:    w_state_next = RUN;
      default:   w_state_next = IDLE;
    endcase
  end

  always_comb begin
    o_ld_ready    = (r_state == LOAD);
    o_load_done   = (r_state == FINISH);
    o_fetch_stall = !((r_state == RUN) && !i_load_start);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we      <= 1'b0;
      r_mem_wa      <= '0;
      r_mem_wd      <= '0;
      r_ra          <= '0;
      r_fetch_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_rd_hold     <= '0;
    end else begin
      r_mem_we      <= w_hs;
      r_fetch_valid <= w_issue;
      r_fetch_err   <= w_misalign;
      if (w_hs) begin
        r_mem_wa <= w_wa;
        r_mem_wd <= i_ld_data;
      end
      if (w_issue)       r_ra      <= i_fetch_addr[INS_ADDRESS-1:2];
      if (r_fetch_valid) r_rd_hold <= i_mem_rd;
    end
  end

  // Read address goes out combinationally so data returns one cycle after the request.
  assign o_mem_ra      = w_issue ? i_fetch_addr[INS_ADDRESS-1:2] : r_ra;
  assign o_fetch_rd    = r_fetch_valid ? i_mem_rd : r_rd_hold;
  assign o_fetch_valid = r_fetch_valid;
  assign o_fetch_err   = r_fetch_err;
  assign o_mem_we      = r_mem_we;
  assign o_mem_wa      = r_mem_wa;
  assign o_mem_wd      = r_mem_wd;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Scoreboard bench for imem_load_arbiter with a behavioural registered-read memory.
module tb_imem_load_arbiter;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic [7:0]  load_count;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        load_done;
  logic        fetch_req;
  logic [8:0]  fetch_addr;
  logic [31:0] fetch_rd;
  logic        fetch_valid;
  logic        fetch_stall;
  logic        fetch_err;
  logic [6:0]  mem_ra;
  logic        mem_we;
  logic [6:0]  mem_wa;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:127];
  logic [31:0] exp_mem [0:127];
  logic [6:0]  exp_wa;
  item_t       wq[$];
  item_t       fq[$];
  int          cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;

  always #5 clk = ~clk;

  imem_load_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_load_start  (load_start),
    .i_load_count  (load_count),
    .i_ld_valid    (ld_valid),
    .i_ld_data     (ld_data),
    .o_ld_ready    (ld_ready),
    .o_load_done   (load_done),
    .i_fetch_req   (fetch_req),
    .i_fetch_addr  (fetch_addr),
    .o_fetch_rd    (fetch_rd),
    .o_fetch_valid (fetch_valid),
    .o_fetch_stall (fetch_stall),
    .o_fetch_err   (fetch_err),
    .o_mem_ra      (mem_ra),
    .o_mem_we      (mem_we),
    .o_mem_wa      (mem_wa),
    .o_mem_wd      (mem_wd),
    .i_mem_rd      (mem_rd)
  );

  // Instruction memory: one write port, registered read.
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem_rd = '0;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_wa] <= mem_wd;
      mem_rd <= mem[mem_ra];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    item_t e;
    if (mem_we) begin
      chk("wr_expected", 32'(wq.size() > 0), 32'd1);
      if (wq.size() > 0) begin
        e = wq.pop_front();
        chk("wr_addr", 32'(mem_wa), e.a);
        chk("wr_data", mem_wd, e.d);
        chk("wr_latency", 32'(cyc), 32'(e.c + 1));
        $display("wr  wa=%0d wd=%h", mem_wa, mem_wd);
      end
    end
    if (fetch_valid) begin
      chk("rd_expected", 32'(fq.size() > 0), 32'd1);
      if (fq.size() > 0) begin
        e = fq.pop_front();
        chk("rd_data", fetch_rd, e.d);
        chk("rd_latency", 32'(cyc), 32'(e.c + 1));
        $display("rd  data=%h", fetch_rd);
      end
    end
    if (load_done) done_cnt++;
    if (fetch_err) err_cnt++;
  end

  task automatic check_reset(input string p);
    chk({p, "_ld_ready"}, 32'(ld_ready), 0);
    chk({p, "_load_done"}, 32'(load_done), 0);
    chk({p, "_fetch_valid"}, 32'(fetch_valid), 0);
    chk({p, "_fetch_err"}, 32'(fetch_err), 0);
    chk({p, "_fetch_stall"}, 32'(fetch_stall), 1);
    chk({p, "_fetch_rd"}, fetch_rd, 0);
    chk({p, "_mem_we"}, 32'(mem_we), 0);
    chk({p, "_mem_wa"}, 32'(mem_wa), 0);
    chk({p, "_mem_ra"}, 32'(mem_ra), 0);
    chk({p, "_mem_wd"}, mem_wd, 0);
  endtask

  task automatic feed_words(input int n, input logic [31:0] base, input bit gap);
    int k = 0;
    int guard = 0;
    bit gapped = 0;
    while (k < n && guard < 1000) begin
      guard++;
      if (gap && (k % 2 == 1) && !gapped) begin
        ld_valid = 1'b0;
        gapped = 1;
        @(posedge clk); #1;
      end else begin
        ld_valid = 1'b1;
        ld_data  = base + k;
        @(negedge clk);
        if (ld_ready) begin
          wq.push_back('{a: 32'(exp_wa), d: base + k, c: cyc});
          exp_mem[exp_wa] = base + k;
          exp_wa = exp_wa + 7'd1;
          k++;
          gapped = 0;
        end
        @(posedge clk); #1;
      end
    end
    ld_valid = 1'b0;
    if (k < n) chk("feed_timeout", k, n);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (load_done) seen = 1;
      else chk("stall_in_load", 32'(fetch_stall), 1);
    end
    chk("load_done_seen", 32'(seen), 1);
    @(posedge clk); #1;
  endtask

  task automatic do_load(input int count, input logic [31:0] base, input bit gap);
    load_start = 1'b1;
    load_count = 8'(count);
    @(posedge clk); #1;
    load_start = 1'b0;
    exp_wa = '0;
    feed_words(count, base, gap);
    wait_done();
  endtask

  task automatic fetch(input logic [8:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    @(negedge clk);
    chk("fetch_stall_run", 32'(fetch_stall), 0);
    if (a[1:0] == 2'b00) fq.push_back('{a: 32'(a), d: exp_mem[a[8:2]], c: cyc});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int e0;
    for (int i = 0; i < 128; i++) exp_mem[i] = '0;
    exp_wa = '0;
    rst_n = 1'b0; load_start = 1'b0; load_count = '0; ld_valid = 1'b0; ld_data = '0;
    fetch_req = 1'b0; fetch_addr = '0;
    repeat (2) @(negedge clk);
    check_reset("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fetch before any load stays stalled; zero-length load then releases it.
    fetch_req = 1'b1; fetch_addr = 9'h010;
    repeat (4) begin
      @(negedge clk);
      chk("pre_load_stall", 32'(fetch_stall), 1);
      chk("pre_load_valid", 32'(fetch_valid), 0);
      @(posedge clk); #1;
    end
    d0 = done_cnt;
    do_load(0, 32'h0, 1'b0);
    fetch(9'h010);
    fetch_req = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("zero_load_done_cnt", done_cnt - d0, 1);

    // Four words with valid gaps, then back-to-back fetch.
    do_load(4, 32'hA0, 1'b1);
    fetch(9'h000); fetch(9'h004); fetch(9'h008); fetch(9'h00C);
    fetch_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Full-depth load, then ld_valid in RUN must be ignored.
    d0 = done_cnt;
    do_load(128, 32'h5000_0000, 1'b0);
    ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
    repeat (3) begin
      @(negedge clk);
      chk("run_ld_ready", 32'(ld_ready), 0);
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    chk("full_load_done_cnt", done_cnt - d0, 1);

    // Misaligned fetch.
    e0 = err_cnt;
    fetch(9'h00C);
    fetch_req = 1'b1; fetch_addr = 9'h006;
    @(negedge clk);
    chk("misalign_mem_ra", 32'(mem_ra), 3);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(negedge clk);
    chk("misalign_err", 32'(fetch_err), 1);
    chk("misalign_valid", 32'(fetch_valid), 0);
    @(negedge clk);
    chk("misalign_err_pulse", 32'(fetch_err), 0);
    chk("misalign_err_cnt", err_cnt - e0, 1);
    @(posedge clk); #1;

    // load_start with a fetch in RUN squashes the read.
    fetch_req = 1'b1; fetch_addr = 9'h004; load_start = 1'b1; load_count = 8'd2;
    @(negedge clk);
    chk("squash_stall", 32'(fetch_stall), 1);
    @(posedge clk); #1;
    load_start = 1'b0;
    exp_wa = '0;
    @(negedge clk);
    chk("reload_ld_ready", 32'(ld_ready), 1);
    chk("reload_stall", 32'(fetch_stall), 1);
    chk("squash_valid", 32'(fetch_valid), 0);
    @(posedge clk); #1;
    feed_words(2, 32'hB0, 1'b0);
    wait_done();
    fetch(9'h004);
    fetch_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset in the middle of a 5-word load, then a fresh 3-word load.
    load_start = 1'b1; load_count = 8'd5;
    @(posedge clk); #1;
    load_start = 1'b0;
    exp_wa = '0;
    feed_words(2, 32'hC0, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    wq.delete();
    fq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_load(3, 32'hD0, 1'b1);
    fetch(9'h000); fetch(9'h004); fetch(9'h008); fetch(9'h00C);
    fetch_req = 1'b0;
    repeat (3) @(posedge clk); #1;

    chk("wq_drained", wq.size(), 0);
    chk("fq_drained", fq.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
